// File: rtl/div_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | div_pkg: shared width and state encoding for the sequential divider  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package div_pkg;

  localparam int DEF_N = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SH   = 2'd1,
    SUB  = 2'd2,
    DONE = 2'd3
  } state_t;

endpackage
`default_nettype wire

// File: rtl/div_control.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | div_control: shift / subtract-restore sequencer for seq_divider      |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module div_control
  import div_pkg::*;
(
  input  logic Clk,
  input  logic Reset,
  input  logic Start,
  input  logic K,
  input  logic Z,
  input  logic B,
  output logic Load,
  output logic LoadZ,
  output logic Sh,
  output logic Sub,
  output logic Busy,
  output logic Done
);

  state_t r_state;
  state_t w_next;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) r_state <= IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    Load   = 1'b0;
    LoadZ  = 1'b0;
    Sh     = 1'b0;
    Sub    = 1'b0;
    Busy   = 1'b0;
    Done   = 1'b0;
    case (r_state)
      IDLE: begin
        if (Start) begin
          if (Z) begin
            LoadZ  = 1'b1;
            w_next = DONE;
          end else begin
            Load   = 1'b1;
            w_next = SH;
          end
        end
      end
      SH: begin
        Busy   = 1'b1;
        Sh     = 1'b1;
        w_next = SUB;
      end
      SUB: begin
        Busy   = 1'b1;
        // Commit the difference only when it did not borrow; otherwise restore.
        Sub    = ~B;
        w_next = K ? DONE : SH;
      end
      DONE: begin
        Done   = 1'b1;
        w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/seq_divider.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | seq_divider: restoring shift-subtract unsigned divider, 1 bit / 2clk |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module seq_divider
  import div_pkg::*;
#(
  parameter int N = DEF_N
) (
  input  logic         Clk,
  input  logic         Reset,
  input  logic         Start,
  input  logic [N-1:0] Dividend,
  input  logic [N-1:0] Divisor,
  output logic [N-1:0] Quotient,
  output logic [N-1:0] Remainder,
  output logic         Busy,
  output logic         Done,
  output logic         DivByZero
);

  localparam int c_cnt_w = $clog2(N + 1);

  // r_acc = {R[N:0], Q[N-1:0]}
  logic [2*N:0]       r_acc;
  logic [N-1:0]       r_dreg;
  logic [c_cnt_w-1:0] r_cnt;
  logic               r_dbz;

  logic               w_load;
  logic               w_loadz;
  logic               w_sh;
  logic               w_sub;
  logic               w_k;
  logic               w_z;
  logic               w_b;
  logic [N+1:0]       w_diff;

  assign w_z    = (Divisor == '0);
  assign w_k    = (r_cnt == '0);
  // One extra MSB so the borrow of the N+1-bit subtraction falls out directly.
  assign w_diff = {1'b0, r_acc[2*N:N]} - {2'b00, r_dreg};
  assign w_b    = w_diff[N+1];

  div_control u_ctrl (
    .Clk   (Clk),
    .Reset (Reset),
    .Start (Start),
    .K     (w_k),
    .Z     (w_z),
    .B     (w_b),
    .Load  (w_load),
    .LoadZ (w_loadz),
    .Sh    (w_sh),
    .Sub   (w_sub),
    .Busy  (Busy),
    .Done  (Done)
  );

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_acc  <= '0;
      r_dreg <= '0;
      r_cnt  <= '0;
      r_dbz  <= 1'b0;
    end else if (w_load) begin
      r_acc  <= {{(N+1){1'b0}}, Dividend};
      r_dreg <= Divisor;
      r_cnt  <= c_cnt_w'(N);
      r_dbz  <= 1'b0;
    end else if (w_loadz) begin
      r_acc  <= {1'b0, Dividend, {N{1'b1}}};
      r_dreg <= Divisor;
      r_dbz  <= 1'b1;
    end else if (w_sh) begin
      r_acc  <= {r_acc[2*N-1:0], 1'b0};
      r_cnt  <= r_cnt - c_cnt_w'(1);
    end else if (w_sub) begin
      r_acc[2*N:N] <= w_diff[N:0];
      r_acc[0]     <= 1'b1;
    end
  end

  assign Quotient  = r_acc[N-1:0];
  assign Remainder = r_acc[2*N-1:N];
  assign DivByZero = r_dbz;

endmodule
`default_nettype wire

// File: doc/seq_divider.md
Name: seq_divider

Overview:
- Sequential restoring shift-subtract unsigned divider. It is the inverse companion of the shift-add multiplier in the Multiplicador area.
- Contains a 2-state-per-bit control FSM (shift / subtract-restore) plus an accumulator datapath.
- Used by the MIPS datapath for DIVU-style operations. Start/Done handshake; one quotient bit per two clocks.

Parameters:
- N, 4, operand width in bits (dividend, divisor, quotient, remainder).

Ports:
- Clk  input  1  clock, rising-edge active.
- Reset  input  1  asynchronous, active-high; forces IDLE and clears all registers.
- Start  input  1  request; sampled only in IDLE.
- Dividend  input  N  unsigned dividend, captured on accepted Start.
- Divisor  input  N  unsigned divisor, captured on accepted Start.
- Quotient  output  N  result quotient, valid from Done onward.
- Remainder  output  N  result remainder, valid from Done onward.
- Busy  output  1  high in SH and SUB states.
- Done  output  1  one-cycle pulse; results valid.
- DivByZero  output  1  high with Done when captured Divisor == 0; held until next accepted Start.

Behaviour:
- Reset (async) sets state=IDLE and ACC=0, DREG=0, CNT=0. Busy=Done=DivByZero=0, Quotient=Remainder=0.
- Registers:
  - ACC: 2N+1 bits, {R[N:0], Q[N-1:0]}.
  - DREG: N-bit divisor.
  - CNT: clog2(N+1) bits.
- States: IDLE, SH, SUB, DONE.
- IDLE, Start=0: stay in IDLE.
- IDLE, Start=1, Divisor!=0:
  - ACC<= {0, Dividend}, DREG<=Divisor, CNT<=N, DivByZero<=0.
  - Next state SH.
- IDLE, Start=1, Divisor==0:
  - ACC<= {0, Dividend, all-ones}. This means R=Dividend, Q=2^N-1.
  - DivByZero<=1. Next state DONE; no iterations.
- SH: ACC<=ACC<<1 (LSB 0), CNT<=CNT-1, next SUB.
- SUB: compute T = R - {0,DREG} in N+1 bits.
  - If T non-negative (borrow=0): R<=T, Q[0]<=1.
  - Otherwise ACC unchanged (restore).
  - Next state: DONE if CNT==0, else SH.
- DONE: Done=1 for exactly this one cycle, next IDLE. Start in DONE is ignored.
- Quotient=ACC[N-1:0], Remainder=ACC[2N-1:N], combinational from ACC. R[N] is always 0 after SUB.
- Outputs are held in IDLE until the next accepted Start reloads ACC.
- Latency:
  - Start accepted at edge t0; Done high in the cycle following edge t0+2N (8 edges for N=4).
  - Divide-by-zero: Done in the cycle after t0+1.
- Start while Busy or in DONE: ignored; no effect on operation.
- Dividend/Divisor changes after acceptance: no effect (captured at t0).
- Dividend < Divisor: Quotient=0, Remainder=Dividend.
- Divisor=1: Quotient=Dividend, Remainder=0.
- Reset asserted mid-operation: immediate return to IDLE with all outputs 0. No Done pulse. The next Start is handled normally.
- Back-to-back: Start held high continuously starts a new division on the IDLE cycle after each DONE.

Decomposition:
- Package div_pkg holds:
  - state encoding constants IDLE=2'd0, SH=2'd1, SUB=2'd2, DONE=2'd3;
  - default width N.
- Sub-module div_control (FSM only).
  - Inputs: Clk, Reset, Start, K (CNT==0), Z (Divisor==0), B (subtract borrow).
  - Outputs: Load, LoadZ, Sh, Sub, Busy, Done.
  - Mirrors the multiplier control split.
- Top seq_divider holds ACC, DREG, CNT and the N+1-bit subtractor.

Test Plan (N=4):
- Dividend=13, Divisor=3, Start pulse -> Busy high 8 cycles; Done pulse; Quotient=4, Remainder=1, DivByZero=0.
- 15/1 -> Quotient=15, Remainder=0. Then 2/9 -> Quotient=0, Remainder=2. Done exactly 8 edges after each accepted Start.
- 7/0 -> Done one cycle after acceptance, DivByZero=1, Quotient=15, Remainder=7. Next 6/2 clears DivByZero, giving Quotient=3, Remainder=0.
- Start 12/5, then re-pulse Start with 9/2 and change inputs during Busy -> result Quotient=2, Remainder=2; a single Done pulse only.
- Start 14/4, assert Reset after 3 cycles -> all outputs 0 immediately, no Done. Then 14/4 -> Quotient=3, Remainder=2.
- Start held high continuously with 10/3 -> repeated Done pulses every 10 cycles (8 + DONE + IDLE), each with Quotient=3, Remainder=1.
